bitonic_sorter_pipe: RTL and testbench
======================================

BITONIC_SORTER_PIPE -- requirements
Module: bitonic_sorter_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning width of one unsigned key in bits.
REQ-002 SHALL have parameter NUM_WAY, default 16, meaning number of keys per vector (power of 2, 2..64).
REQ-003 SHALL have parameter TAG_WIDTH, default 4, meaning sideband tag carried unchanged with each vector.
REQ-004 SHALL have derived constant STAGES = L*(L+1)/2 with L = log2(NUM_WAY), meaning pipeline depth.
REQ-005 SHALL have port clk  input  1  meaning sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  meaning reset, synchronous and active-low.
REQ-007 SHALL have port in_valid  input  1  meaning input vector present.
REQ-008 SHALL have port in_ready  output  1  meaning block accepts the input vector this cycle.
REQ-009 SHALL have port in_data  input  WIDTH*NUM_WAY  meaning flattened keys; key i at bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port in_desc  input  1  meaning 1 = sort descending, 0 = ascending, per vector.
REQ-011 SHALL have port in_tag  input  TAG_WIDTH  meaning sideband tag.
REQ-012 SHALL have port out_valid  output  1  meaning sorted vector present.
REQ-013 SHALL have port out_ready  input  1  meaning downstream accepts the output.
REQ-014 SHALL have port out_data  output  WIDTH*NUM_WAY  meaning sorted keys, same flattening as in_data.
REQ-015 SHALL have port out_tag  output  TAG_WIDTH  meaning tag of the vector on out_data.

Function
REQ-016 SHALL implement a full bitonic sorting network of STAGES compare-exchange stages, with a register bank (data, desc, tag, valid) after every stage.
REQ-017 SHALL sort ascending (key 0 smallest) when the vector's desc bit is 0, descending (key 0 largest) when 1; the desc bit travels with its vector, so mixed-mode vectors coexist in the pipe.
REQ-018 SHALL compare keys as unsigned WIDTH-bit values; on equal keys the compare-exchange SHALL leave both positions unchanged.
REQ-019 SHALL have latency exactly STAGES cycles from accepting handshake (in_valid & in_ready) to out_valid, when out_ready is held 1.
REQ-020 SHALL compute global advance = out_ready | ~out_valid; all stage registers load only when advance = 1, otherwise hold.
REQ-021 SHALL drive in_ready = advance (combinational, no dependence on in_valid).
REQ-022 SHALL load stage-0 valid with in_valid & in_ready; when in_valid = 0 a bubble (valid 0) enters and bubbles are not collapsed.
REQ-023 SHALL sustain throughput of one vector per cycle while out_ready = 1.
REQ-024 SHALL keep out_data, out_tag stable while out_valid = 1 and out_ready = 0.
REQ-025 SHALL allow simultaneous accept and emit in the same cycle without loss or duplication.
REQ-026 SHALL ignore in_data/in_desc/in_tag when in_valid = 0 or in_ready = 0.

Reset
REQ-027 SHALL clear all stage valid bits to 0 when rst_n = 0 at a clock edge; out_valid = 0 the cycle after.
REQ-028 SHALL reset out_data, out_tag and all data/tag/desc registers to 0.
REQ-029 SHALL discard every in-flight vector on reset mid-operation; in_ready = 1 during and after reset.

Structure
REQ-030 SHALL place in package bitonic_pkg: clog2 helper, STAGES computation function, and per-stage (block size, distance) lookup functions.
REQ-031 SHALL use one sub-module bitonic_cas_stage (combinational, parametrised by WIDTH, NUM_WAY, block size, distance) instantiated STAGES times via generate; direction per pair = desc XOR (bit of index selecting the sub-sequence).
REQ-032 SHALL contain no storage other than the STAGES stage register banks.

Verification (NUM_WAY=4, WIDTH=8, STAGES=3)
REQ-033 SHALL cover: in_data keys {0:9,1:3,2:7,3:1}, desc=0, out_ready=1 -> after 3 cycles out_valid=1, keys {1,3,7,9}.
REQ-034 SHALL cover: same keys, desc=1, tag=5 -> keys {9,7,3,1}, out_tag=5.
REQ-035 SHALL cover: duplicates {0xFF,0x00,0xFF,0x00} ascending -> {0x00,0x00,0xFF,0xFF}; all-equal {4,4,4,4} -> {4,4,4,4}.
REQ-036 SHALL cover: back-to-back 8 vectors alternating desc, tags 0..7, out_ready=1 -> 8 consecutive out_valid cycles, tags in order 0..7, each correctly sorted.
REQ-037 SHALL cover: out_ready=0 for 5 cycles with pipe full -> in_ready=0, out_data stable, no vector lost or duplicated after out_ready returns to 1.
REQ-038 SHALL cover: rst_n=0 for one cycle with 2 vectors in flight -> out_valid=0 next cycle and no stale vector ever emitted.

Source files
------------

// File: rtl/bitonic_pkg.sv
// Shared sizing helpers for the bitonic sorter: log2, pipeline depth and the
// (block size, distance) pair that each compare-exchange stage operates on.
package bitonic_pkg;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int num_stages(input int n);
      int l;
      l = clog2(n);
      return l * (l + 1) / 2;
   endfunction

   // Stage order: block size 2,4,..,n outer; distance block/2 down to 1 inner.
   function automatic int stage_blk(input int n, input int s);
      int idx;
      int r;
      idx = 0;
      r   = 2;
      for (int k = 1; k <= clog2(n); k++) begin
         for (int j = k - 1; j >= 0; j--) begin
            if (idx == s) r = 1 << k;
            idx++;
         end
      end
      return r;
   endfunction

   function automatic int stage_dist(input int n, input int s);
      int idx;
      int r;
      idx = 0;
      r   = 1;
      for (int k = 1; k <= clog2(n); k++) begin
         for (int j = k - 1; j >= 0; j--) begin
            if (idx == s) r = 1 << j;
            idx++;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bitonic_cas_stage.sv
// One combinational compare-exchange column of the bitonic network; every key
// is paired with the key DIST positions above it.
module bitonic_cas_stage
   import bitonic_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int NUM_WAY = 16,
   parameter int BLK     = 2,
   parameter int DIST    = 1
) (
   input  logic [WIDTH*NUM_WAY-1:0] in_data,
   input  logic                     in_desc,
   output logic [WIDTH*NUM_WAY-1:0] out_data
);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_WAY; gi++) begin : g_pair
         if ((gi & DIST) == 0) begin : g_lo
            // Odd sub-sequences of the current block sort the opposite way.
            localparam bit FLIP = ((gi & BLK) != 0);
            logic [WIDTH-1:0] key_a;
            logic [WIDTH-1:0] key_b;
            logic             dir_desc;
            logic             swap;

            assign key_a    = in_data[gi*WIDTH +: WIDTH];
            assign key_b    = in_data[(gi+DIST)*WIDTH +: WIDTH];
            assign dir_desc = in_desc ^ FLIP;
            assign swap     = dir_desc ? (key_a < key_b) : (key_a > key_b);

            assign out_data[gi*WIDTH +: WIDTH]        = swap ? key_b : key_a;
            assign out_data[(gi+DIST)*WIDTH +: WIDTH] = swap ? key_a : key_b;
         end
      end
   endgenerate

endmodule

// File: rtl/bitonic_sorter_pipe.sv
// Fully pipelined bitonic sorter: one compare-exchange column per stage, one
// register bank after each column, single global stall driven by the output.
module bitonic_sorter_pipe
   import bitonic_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int NUM_WAY   = 16,
   parameter int TAG_WIDTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH*NUM_WAY-1:0] in_data,
   input  logic                     in_desc,
   input  logic [TAG_WIDTH-1:0]     in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH*NUM_WAY-1:0] out_data,
   output logic [TAG_WIDTH-1:0]     out_tag
);

   localparam int STAGES = num_stages(NUM_WAY);
   localparam int DW     = WIDTH * NUM_WAY;

   // Element s is the input of stage s; element STAGES is the pipe output.
   logic [DW-1:0]        pipe_data  [STAGES+1];
   logic                 pipe_desc  [STAGES+1];
   logic [TAG_WIDTH-1:0] pipe_tag   [STAGES+1];
   logic                 pipe_valid [STAGES+1];
   logic                 advance;

   // Reset also opens the pipe so the input side reports ready throughout.
   assign advance  = out_ready | ~out_valid | ~rst_n;
   assign in_ready = advance;

   assign pipe_data[0]  = in_data;
   assign pipe_desc[0]  = in_desc;
   assign pipe_tag[0]   = in_tag;
   assign pipe_valid[0] = in_valid & in_ready;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         logic [DW-1:0]        data_next;
         logic [DW-1:0]        data_reg;
         logic                 desc_reg;
         logic [TAG_WIDTH-1:0] tag_reg;
         logic                 valid_reg;

         bitonic_cas_stage #(
            .WIDTH   (WIDTH),
            .NUM_WAY (NUM_WAY),
            .BLK     (stage_blk(NUM_WAY, gi)),
            .DIST    (stage_dist(NUM_WAY, gi))
         ) u_cas (
            .in_data  (pipe_data[gi]),
            .in_desc  (pipe_desc[gi]),
            .out_data (data_next)
         );

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               data_reg  <= '0;
               desc_reg  <= 1'b0;
               tag_reg   <= '0;
               valid_reg <= 1'b0;
            end else if (advance) begin
               data_reg  <= data_next;
               desc_reg  <= pipe_desc[gi];
               tag_reg   <= pipe_tag[gi];
               valid_reg <= pipe_valid[gi];
            end
         end

         assign pipe_data[gi+1]  = data_reg;
         assign pipe_desc[gi+1]  = desc_reg;
         assign pipe_tag[gi+1]   = tag_reg;
         assign pipe_valid[gi+1] = valid_reg;
      end
   endgenerate

   assign out_valid = pipe_valid[STAGES];
   assign out_data  = pipe_data[STAGES];
   assign out_tag   = pipe_tag[STAGES];

endmodule

// File: tb/tb_bitonic_sorter_pipe.sv
// Scoreboard bench for the 4-way 8-bit bitonic sorter: directed vectors with
// hand-sorted expectations, checked by an independent output monitor.
module tb_bitonic_sorter_pipe;

   localparam int WIDTH     = 8;
   localparam int NUM_WAY   = 4;
   localparam int TAG_WIDTH = 4;
   localparam int DW        = WIDTH * NUM_WAY;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [DW-1:0]        in_data = '0;
   logic                 in_desc = 1'b0;
   logic [TAG_WIDTH-1:0] in_tag = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b1;
   logic [DW-1:0]        out_data;
   logic [TAG_WIDTH-1:0] out_tag;

   always #5 clk = ~clk;

   bitonic_sorter_pipe #(
      .WIDTH     (WIDTH),
      .NUM_WAY   (NUM_WAY),
      .TAG_WIDTH (TAG_WIDTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_desc   (in_desc),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
   );

   typedef struct packed {
      logic [DW-1:0]        data;
      logic [TAG_WIDTH-1:0] tag;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_pushed = 0;
   int   n_popped = 0;
   int   run_len  = 0;
   int   run_max  = 0;

   // Burst table: key i at byte i, even entries ascending, odd descending.
   logic [DW-1:0] burst_in  [8] = '{32'h01080205, 32'h817F8010, 32'h02010303, 32'hFE01FF00,
                                    32'h04030201, 32'h04030201, 32'h01020304, 32'h00AA55AA};
   logic [DW-1:0] burst_exp [8] = '{32'h08050201, 32'h107F8081, 32'h03030201, 32'h0001FEFF,
                                    32'h04030201, 32'h01020304, 32'h04030201, 32'h0055AAAA};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the vector was taken.
   task automatic send(input logic [DW-1:0] d, input logic desc, input logic [TAG_WIDTH-1:0] tag,
                       input logic [DW-1:0] exp);
      exp_t e;
      int   waited;
      waited   = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_desc  = desc;
      in_tag   = tag;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            e.data = exp;
            e.tag  = tag;
            sb.push_back(e);
            n_pushed++;
            $display("send tag=%0d data=%h desc=%0d expect=%h", tag, d, desc, exp);
            break;
         end
         waited++;
         if (waited > 50) begin
            check("in_ready_timeout", 32'd0, 32'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (out_valid && out_ready) begin
         run_len++;
         if (run_len > run_max) run_max = run_len;
         if (sb.size() == 0) begin
            check("unexpected_output", {28'd0, out_tag}, 32'hFFFFFFFF);
         end else begin
            e = sb.pop_front();
            n_popped++;
            $display("recv tag=%0d data=%h", out_tag, out_data);
            check("out_data", out_data, e.data);
            check("out_tag", {28'd0, out_tag}, {28'd0, e.tag});
         end
      end else begin
         run_len = 0;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int lat;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_tag", {28'd0, out_tag}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single ascending vector and its latency
      send(32'h01070309, 1'b0, 4'd0, 32'h09070301);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("latency", lat, 32'd3);
      @(posedge clk);
      #1;
      idle(3);

      // Descending with tag, duplicates, all-equal
      send(32'h01070309, 1'b1, 4'd5, 32'h01030709);
      send(32'h00FF00FF, 1'b0, 4'd2, 32'hFFFF0000);
      send(32'h04040404, 1'b0, 4'd3, 32'h04040404);
      send(32'h04040404, 1'b1, 4'd4, 32'h04040404);
      idle(6);

      // Back-to-back burst with alternating direction
      run_max = 0;
      for (int i = 0; i < 8; i++)
         send(burst_in[i], i[0], i[3:0], burst_exp[i]);
      idle(6);
      check("burst_streak", run_max, 32'd8);

      // Full pipe stalled by the consumer
      out_ready = 1'b0;
      send(32'h01070309, 1'b0, 4'd8, 32'h09070301);
      send(32'h01070309, 1'b1, 4'd9, 32'h01030709);
      send(32'h00FF00FF, 1'b0, 4'd10, 32'hFFFF0000);
      in_valid = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("stall_in_ready", {31'd0, in_ready}, 32'd0);
         check("stall_out_valid", {31'd0, out_valid}, 32'd1);
         check("stall_out_data", out_data, 32'h09070301);
         check("stall_out_tag", {28'd0, out_tag}, 32'd8);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(32'h02040103, 1'b1, 4'd11, 32'h01020304);
      idle(8);
      check("stall_count", n_popped, n_pushed);

      // Reset with two vectors in flight
      send(32'h01080205, 1'b0, 4'd12, 32'h08050201);
      send(32'h817F8010, 1'b1, 4'd13, 32'h107F8081);
      in_valid = 1'b0;
      rst_n = 1'b0;
      sb.delete();
      n_pushed -= 2;
      @(negedge clk);
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check("no_stale_valid", {31'd0, out_valid}, 32'd0);
      end
      @(posedge clk);
      #1;

      // Normal traffic after reset
      send(32'h01070309, 1'b1, 4'd1, 32'h01030709);
      idle(6);

      check("sb_empty", sb.size(), 32'd0);
      check("final_count", n_popped, n_pushed);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
